// File: rtl/alu_seq_ctrl_if.sv
// Command, ALU datapath and result signals of the ALU sequencer.
// slave = the sequencer itself, master = the command source plus datapath and consumer.
interface alu_seq_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        ld_a;
  logic        ld_b;
  logic        ld_f;
  logic [31:0] alu_f;
  logic [3:0]  alu_fr;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_f;
  logic [3:0]  res_fr;
  logic        res_err;
  logic        busy;
  logic [15:0] op_count;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_f, alu_fr, res_ready,
    output cmd_ready, alu_op, alu_a, alu_b, ld_a, ld_b, ld_f,
           res_valid, res_f, res_fr, res_err, busy, op_count
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_f, alu_fr, res_ready,
    input  cmd_ready, alu_op, alu_a, alu_b, ld_a, ld_b, ld_f,
           res_valid, res_f, res_fr, res_err, busy, op_count
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencer for a multi-cycle ALU datapath: load A, load B, execute, capture, hand off result.
// Every output is registered in the single FSM block.
module alu_seq_ctrl #(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter logic [3:0]  OP_MAX      = 4'd8
) (
  input logic           clk,
  input logic           rst_n,
  alu_seq_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, CAPTURE, DONE} state_t;

  localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

  state_t     state;
  logic [3:0] exec_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      exec_cnt      <= 4'd0;
      bus.cmd_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.ld_a      <= 1'b0;
      bus.ld_b      <= 1'b0;
      bus.ld_f      <= 1'b0;
      bus.alu_op    <= 4'd0;
      bus.alu_a     <= 32'd0;
      bus.alu_b     <= 32'd0;
      bus.res_f     <= 32'd0;
      bus.res_fr    <= 4'd0;
      bus.res_err   <= 1'b0;
      bus.op_count  <= 16'd0;
    end else begin
      // load strobes are single-cycle pulses unless a state re-arms them
      bus.ld_a <= 1'b0;
      bus.ld_b <= 1'b0;
      bus.ld_f <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.alu_op    <= bus.cmd_op;
            bus.alu_a     <= bus.cmd_a;
            bus.alu_b     <= bus.cmd_b;
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b1;
            if (bus.cmd_op > OP_MAX) begin
              // illegal opcode skips the datapath entirely
              state         <= DONE;
              bus.res_f     <= 32'd0;
              bus.res_fr    <= 4'd0;
              bus.res_err   <= 1'b1;
              bus.res_valid <= 1'b1;
            end else begin
              state    <= LOAD_A;
              bus.ld_a <= 1'b1;
            end
          end
        end
        LOAD_A: begin
          state    <= LOAD_B;
          bus.ld_b <= 1'b1;
        end
        LOAD_B: begin
          state    <= EXEC;
          exec_cnt <= EXEC_LAST;
          bus.ld_f <= (EXEC_LAST == 4'd0);
        end
        EXEC: begin
          if (exec_cnt == 4'd0) begin
            state <= CAPTURE;
          end else begin
            exec_cnt <= exec_cnt - 4'd1;
            bus.ld_f <= (exec_cnt == 4'd1);
          end
        end
        CAPTURE: begin
          state         <= DONE;
          bus.res_f     <= bus.alu_f;
          bus.res_fr    <= bus.alu_fr;
          bus.res_err   <= 1'b0;
          bus.res_valid <= 1'b1;
        end
        DONE: begin
          if (bus.res_ready) begin
            state         <= IDLE;
            bus.res_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            bus.busy      <= 1'b0;
            bus.op_count  <= bus.op_count + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: two instances (EXEC_CYCLES 1 and 3) with a behavioural
// datapath; directed commands push hand-computed results, a negedge monitor pops and compares.
module tb_alu_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_ctrl_if b1 ();
  alu_seq_ctrl_if b3 ();

  alu_seq_ctrl #(.EXEC_CYCLES(1)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  alu_seq_ctrl #(.EXEC_CYCLES(3)) u_d3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

  typedef struct {
    logic [31:0] f;
    logic [3:0]  fr;
    logic        err;
    int          lat, la, lb, lf, nld;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // behavioural ALU datapath: opcode table and flag format {neg, zero, lsb, parity}
  function automatic logic [31:0] f_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: f_op = a;
      4'd1: f_op = a + b;
      4'd2: f_op = a - b;
      4'd3: f_op = a & b;
      4'd4: f_op = a | b;
      4'd5: f_op = a ^ b;
      4'd6: f_op = a << b[4:0];
      4'd7: f_op = a >> b[4:0];
      4'd8: f_op = ~a;
      default: f_op = 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] fr_of(input logic [31:0] f);
    fr_of = {f[31], f == 32'd0, f[0], ^f};
  endfunction

  logic [31:0] ra1, rb1, ra3, rb3;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      ra1 <= 32'd0; rb1 <= 32'd0; b1.alu_f <= 32'd0; b1.alu_fr <= 4'd0;
      ra3 <= 32'd0; rb3 <= 32'd0; b3.alu_f <= 32'd0; b3.alu_fr <= 4'd0;
    end else begin
      if (b1.ld_a) ra1 <= b1.alu_a;
      if (b1.ld_b) rb1 <= b1.alu_b;
      if (b1.ld_f) begin
        b1.alu_f  <= f_op(b1.alu_op, ra1, rb1);
        b1.alu_fr <= fr_of(f_op(b1.alu_op, ra1, rb1));
      end
      if (b3.ld_a) ra3 <= b3.alu_a;
      if (b3.ld_b) rb3 <= b3.alu_b;
      if (b3.ld_f) begin
        b3.alu_f  <= f_op(b3.alu_op, ra3, rb3);
        b3.alu_fr <= fr_of(f_op(b3.alu_op, ra3, rb3));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] f, input logic [3:0] fr, input logic err,
                              input int lat, input int la, input int lb, input int lf, input int nld);
    exp_t e;
    e.f = f; e.fr = fr; e.err = err; e.lat = lat; e.la = la; e.lb = lb; e.lf = lf; e.nld = nld;
    return e;
  endfunction

  // monitor state per instance (0 = EXEC_CYCLES 1, 1 = EXEC_CYCLES 3)
  int acc_c[2], la[2], lb[2], lf[2], nld[2], lat[2];
  logic seen[2];
  logic [31:0] hf[2];
  logic [3:0] hfr[2];
  logic herr[2];

  task automatic mon(input int id, input logic acc, input logic lda, input logic ldb, input logic ldf,
                     input logic rv, input logic rr, input logic [31:0] f, input logic [3:0] fr, input logic err);
    exp_t e;
    if (lda) begin la[id] = cyc - acc_c[id]; nld[id]++; end
    if (ldb) begin lb[id] = cyc - acc_c[id]; nld[id]++; end
    if (ldf) begin lf[id] = cyc - acc_c[id]; nld[id]++; end
    if (rv) begin
      if (!seen[id]) begin
        seen[id] = 1'b1; lat[id] = cyc - acc_c[id];
        hf[id] = f; hfr[id] = fr; herr[id] = err;
      end else begin
        chk("hold_res_f", f, hf[id]);
        chk("hold_res_fr", 32'(fr), 32'(hfr[id]));
        chk("hold_res_err", 32'(err), 32'(herr[id]));
      end
      if (rr) begin
        if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_result: dut%0d offered res_f=%h with nothing expected", id, f);
        end else begin
          if (id == 0) e = q0.pop_front(); else e = q1.pop_front();
          chk("res_f", f, e.f);
          chk("res_fr", 32'(fr), 32'(e.fr));
          chk("res_err", 32'(err), 32'(e.err));
          chk("res_latency", lat[id], e.lat);
          chk("ld_a_cycle", la[id], e.la);
          chk("ld_b_cycle", lb[id], e.lb);
          chk("ld_f_cycle", lf[id], e.lf);
          chk("ld_pulse_count", nld[id], e.nld);
        end
        seen[id] = 1'b0;
      end
    end
    if (acc) begin
      acc_c[id] = cyc; la[id] = -1; lb[id] = -1; lf[id] = -1; nld[id] = 0; seen[id] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, b1.cmd_valid && b1.cmd_ready, b1.ld_a, b1.ld_b, b1.ld_f,
          b1.res_valid, b1.res_ready, b1.res_f, b1.res_fr, b1.res_err);
      mon(1, b3.cmd_valid && b3.cmd_ready, b3.ld_a, b3.ld_b, b3.ld_f,
          b3.res_valid, b3.res_ready, b3.res_f, b3.res_fr, b3.res_err);
    end
  end

  task automatic drive_cmd(input int id, input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (id == 0) begin
      b1.cmd_valid = v; b1.cmd_op = op; b1.cmd_a = a; b1.cmd_b = b;
    end else begin
      b3.cmd_valid = v; b3.cmd_op = op; b3.cmd_a = a; b3.cmd_b = b;
    end
  endtask

  // offer a command until accepted; returns in cycle 1 after the accepting edge
  task automatic issue(input int id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input exp_t e, input bit push);
    int k;
    if (push) begin
      if (id == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk); #1;
    drive_cmd(id, 1'b1, op, a, b);
    k = 0;
    while (!(id == 0 ? b1.cmd_ready : b3.cmd_ready) && k < 50) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: dut%0d cmd_ready low for %0d cycles, required high", id, k);
    end
    @(posedge clk); #1;
    drive_cmd(id, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  task automatic drain(input int id);
    int k;
    k = 0;
    while ((id == 0 ? q0.size() : q1.size()) != 0 && k < 60) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 60) begin
      n_cmp++; n_bad++;
      $display("FAIL result_timeout: dut%0d still has %0d pending, required 0", id, (id == 0 ? q0.size() : q1.size()));
      if (id == 0) q0.delete(); else q1.delete();
    end
  endtask

  task automatic chk_rst(input string tag, input logic cr, input logic bz, input logic rv,
                         input logic lda, input logic ldb, input logic ldf, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] f,
                         input logic [3:0] fr, input logic err, input logic [15:0] oc);
    chk({tag, "_cmd_ready"}, 32'(cr), 32'd1);
    chk({tag, "_busy"}, 32'(bz), 32'd0);
    chk({tag, "_res_valid"}, 32'(rv), 32'd0);
    chk({tag, "_ld_a"}, 32'(lda), 32'd0);
    chk({tag, "_ld_b"}, 32'(ldb), 32'd0);
    chk({tag, "_ld_f"}, 32'(ldf), 32'd0);
    chk({tag, "_alu_op"}, 32'(op), 32'd0);
    chk({tag, "_alu_a"}, a, 32'd0);
    chk({tag, "_alu_b"}, b, 32'd0);
    chk({tag, "_res_f"}, f, 32'd0);
    chk({tag, "_res_fr"}, 32'(fr), 32'd0);
    chk({tag, "_res_err"}, 32'(err), 32'd0);
    chk({tag, "_op_count"}, 32'(oc), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    exp_t ill;
    ill = mk(32'd0, 4'd0, 1'b1, 1, -1, -1, -1, 0);
    drive_cmd(0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive_cmd(1, 1'b0, 4'd0, 32'd0, 32'd0);
    b1.res_ready = 1'b1;
    b3.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_rst("rst1", b1.cmd_ready, b1.busy, b1.res_valid, b1.ld_a, b1.ld_b, b1.ld_f, b1.alu_op,
            b1.alu_a, b1.alu_b, b1.res_f, b1.res_fr, b1.res_err, b1.op_count);
    chk_rst("rst3", b3.cmd_ready, b3.busy, b3.res_valid, b3.ld_a, b3.ld_b, b3.ld_f, b3.alu_op,
            b3.alu_a, b3.alu_b, b3.res_f, b3.res_fr, b3.res_err, b3.op_count);

    // 5+3, EXEC_CYCLES=1: ld_a@1 ld_b@2 ld_f@3 res@5
    issue(0, 4'd1, 32'd5, 32'd3, mk(32'd8, 4'b0001, 1'b0, 5, 1, 2, 3, 3), 1'b1);
    drain(0);
    chk("op_count_after_first", 32'(b1.op_count), 32'd1);

    // same op, EXEC_CYCLES=3: ld_f@5 only, res@7
    issue(1, 4'd1, 32'd5, 32'd3, mk(32'd8, 4'b0001, 1'b0, 7, 1, 2, 5, 3), 1'b1);
    drain(1);
    chk("op_count_d3", 32'(b3.op_count), 32'd1);

    issue(0, 4'hF, 32'h1234_5678, 32'h9ABC_DEF0, ill, 1'b1);
    drain(0);
    chk("op_count_after_illegal", 32'(b1.op_count), 32'd2);

    // opcode boundary: OP_MAX legal, OP_MAX+1 illegal
    issue(0, 4'd8, 32'd0, 32'd0, mk(32'hFFFF_FFFF, 4'b1010, 1'b0, 5, 1, 2, 3, 3), 1'b1);
    drain(0);
    issue(0, 4'd9, 32'd7, 32'd7, ill, 1'b1);
    drain(0);
    issue(0, 4'd2, 32'd3, 32'd3, mk(32'd0, 4'b0100, 1'b0, 5, 1, 2, 3, 3), 1'b1);
    drain(0);
    issue(0, 4'd3, 32'hFFFF_0000, 32'h1234_5678, mk(32'h1234_0000, 4'b0001, 1'b0, 5, 1, 2, 3, 3), 1'b1);
    drain(0);
    chk("op_count_after_six", 32'(b1.op_count), 32'd6);

    // consumer backpressure: result held while new commands are offered and ignored
    b1.res_ready = 1'b0;
    issue(0, 4'd5, 32'hF0F0_F0F0, 32'h0F0F_0FFF, mk(32'hFFFF_FF0F, 4'b1010, 1'b0, 5, 1, 2, 3, 3), 1'b1);
    k = 0;
    while (!b1.res_valid && k < 20) begin @(posedge clk); #1; k++; end
    chk("res_valid_under_backpressure", 32'(b1.res_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      drive_cmd(0, i[0], 4'd1, 32'hDEAD_0000 + 32'(i), 32'd1);
      @(posedge clk); #1;
    end
    drive_cmd(0, 1'b0, 4'd0, 32'd0, 32'd0);
    chk("alu_a_kept", b1.alu_a, 32'hF0F0_F0F0);
    chk("alu_op_kept", 32'(b1.alu_op), 32'd5);
    chk("res_valid_still", 32'(b1.res_valid), 32'd1);
    chk("busy_in_done", 32'(b1.busy), 32'd1);
    b1.res_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_cmd_ready", 32'(b1.cmd_ready), 32'd1);
    chk("idle_busy", 32'(b1.busy), 32'd0);
    chk("idle_res_valid", 32'(b1.res_valid), 32'd0);
    chk("op_count_after_bp", 32'(b1.op_count), 32'd7);
    chk("bp_queue_empty", 32'(q0.size()), 32'd0);

    // the preload stands in for 65535 completed ops
    @(posedge clk); #1;
    force b1.op_count = 16'hFFFF;
    @(posedge clk); #1;
    release b1.op_count;
    chk("op_count_preload", 32'(b1.op_count), 32'h0000_FFFF);
    issue(0, 4'hC, 32'd1, 32'd2, ill, 1'b1);
    drain(0);
    chk("op_count_wrap", 32'(b1.op_count), 32'd0);

    // reset for one edge mid-EXEC abandons the op
    issue(1, 4'd1, 32'd7, 32'd9, mk(32'd16, 4'b0001, 1'b0, 7, 1, 2, 5, 3), 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy_in_exec", 32'(b3.busy), 32'd1);
    chk("ld_f_first_exec", 32'(b3.ld_f), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_rst("rst_exec", b3.cmd_ready, b3.busy, b3.res_valid, b3.ld_a, b3.ld_b, b3.ld_f, b3.alu_op,
            b3.alu_a, b3.alu_b, b3.res_f, b3.res_fr, b3.res_err, b3.op_count);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("no_abandoned_result", 32'(b3.res_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter EXEC_CYCLES, default 1, sets EXEC-state dwell cycles (legal range 1..15).
REQ-002 Parameter OP_MAX, default 4'd8, is the highest legal opcode; cmd_op > OP_MAX is illegal.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  is the synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 Port cmd_valid  input  1  means a command is offered.
REQ-006 Port cmd_ready  output  1  means the block accepts a command this cycle.
REQ-007 Ports cmd_op, cmd_a and cmd_b  input  4/32/32  carry the opcode and operands, valid with cmd_valid.
REQ-008 Ports alu_op, alu_a and alu_b  output  4/32/32  drive the ALU datapath opcode and operand inputs.
REQ-009 Ports ld_a, ld_b and ld_f  output  1 each  are load strobes for the datapath A, B and F/FR registers.
REQ-010 Ports alu_f and alu_fr  input  32/4  carry the datapath F and FR register outputs.
REQ-011 Port res_valid  output  1  means a result is offered.
REQ-012 Port res_ready  input  1  means the consumer accepts the result.
REQ-013 Ports res_f, res_fr and res_err  output  32/4/1  carry the result, flags and illegal-op indication.
REQ-014 Port busy  output  1  is high whenever the state is not IDLE.
REQ-015 Port op_count  output  16  counts completed result handshakes.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD_A, LOAD_B, EXEC, CAPTURE and DONE.
REQ-017 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a clock edge with cmd_valid&&cmd_ready.
REQ-018 On acceptance, cmd_op/cmd_a/cmd_b SHALL be latched internally; alu_op/alu_a/alu_b SHALL drive the latched values and stay stable until the next acceptance.
REQ-019 Legal op: IDLE->LOAD_A->LOAD_B->EXEC->CAPTURE->DONE; each of LOAD_A, LOAD_B and CAPTURE lasts exactly 1 cycle.
REQ-020 ld_a SHALL be high only in LOAD_A, ld_b only in LOAD_B, and each SHALL be a single-cycle pulse.
REQ-021 EXEC SHALL last EXEC_CYCLES cycles via a down-counter; ld_f SHALL pulse high only in the last EXEC cycle.
REQ-022 In CAPTURE, alu_f and alu_fr SHALL be registered into res_f and res_fr, and res_err SHALL be cleared to 0.
REQ-023 Illegal op: IDLE->DONE directly, with no ld_* pulses, res_f=0, res_fr=0 and res_err=1.
REQ-024 In DONE, res_valid SHALL be 1 and res_f/res_fr/res_err SHALL be held stable until res_ready.
REQ-025 DONE with res_ready SHALL go to IDLE and increment op_count, which wraps from 0xFFFF to 0.
REQ-026 A legal-op result SHALL assert res_valid on cycle 4+EXEC_CYCLES after the acceptance edge (cycle 0 = handshake cycle).
REQ-027 An illegal-op result SHALL assert res_valid on cycle 1 after acceptance.
REQ-028 cmd_valid outside IDLE SHALL be ignored, with no effect on state or latched operands.
REQ-029 res_ready outside DONE SHALL be ignored.
REQ-030 Minimum command spacing is one IDLE cycle, so cmd_ready is never high in the cycle res_valid falls.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force IDLE from any state, including mid-EXEC and mid-DONE, and abandon any in-flight op without a result.
REQ-032 The reset values SHALL be: cmd_ready=1 (first cycle after reset), busy=0, res_valid=0, ld_a=ld_b=ld_f=0, and alu_op/alu_a/alu_b/res_f/res_fr/res_err/op_count/EXEC counter all 0.

Verification
REQ-033 EXEC_CYCLES=1; op=4'd1, A=32'h0000_0005, B=32'h0000_0003; model F=F_op(A,B) registered on ld_f; res_ready held 1 -> ld_a at cycle 1, ld_b at 2, ld_f at 3, res_valid at 5 with res_f=model F, res_err=0, op_count=1.
REQ-034 EXEC_CYCLES=3, same op -> ld_f only at cycle 5, res_valid at cycle 7, and ld_f high for exactly one cycle.
REQ-035 op=4'hF (illegal) -> res_valid at cycle 1, res_err=1, res_f=0, res_fr=0, no ld_* pulses, op_count increments.
REQ-036 res_ready held 0 for 10 cycles in DONE -> res_valid and res_f stable throughout; cmd_valid pulses meanwhile are not accepted; res_ready=1 -> IDLE next cycle.
REQ-037 rst_n=0 for one edge during EXEC -> next cycle is IDLE with busy=0 and all outputs at reset values; no res_valid for the abandoned op.
REQ-038 With op_count preset to 0xFFFF by 65535 completed ops, one more completed op -> op_count=0.
